// File: rtl/inst_encoder.sv
// Buffered RV32 instruction encoder: encodes instruction numbers plus operand
// fields into machine words and queues them in order through a small FIFO.

`ifndef INST_NUM_WIDTH
`define INST_NUM_WIDTH 3
`endif
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef INV
`define INV    3'd0
`endif
`ifndef ADDI
`define ADDI   3'd1
`endif
`ifndef ADD
`define ADD    3'd2
`endif
`ifndef LW
`define LW     3'd3
`endif
`ifndef SW
`define SW     3'd4
`endif
`ifndef BEQ
`define BEQ    3'd5
`endif
`ifndef EBREAK
`define EBREAK 3'd6
`endif

module inst_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [`INST_NUM_WIDTH-1:0] in_num,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [31:0]                in_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`ISA_WIDTH-1:0]      out_inst,
    output logic                       err,
    output logic [CNT_WIDTH-1:0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned W     = `ISA_WIDTH;

    logic [W-1:0]         mem_q [DEPTH];
    logic [W-1:0]         mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 err_q, err_d;

    logic [W-1:0]         enc_c;
    logic                 supported_c;
    logic                 full_c;
    logic                 accept_c;
    logic                 push_c;
    logic                 pop_c;
    logic [18:0]          unused_imm_c;

    // Immediate bits above the widest format (B-type, imm[12]) never reach a word.
    assign unused_imm_c = in_imm[31:13];

    // Combinational field packing per instruction format.
    always_comb begin
        enc_c       = '0;
        supported_c = 1'b1;
        case (in_num)
            `ADDI:   enc_c = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            `ADD:    enc_c = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            `LW:     enc_c = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            `SW:     enc_c = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            `BEQ:    enc_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                              in_imm[4:1], in_imm[11], 7'b1100011};
            `EBREAK: enc_c = 32'h0010_0073;
            default: supported_c = 1'b0;
        endcase
    end

    assign full_c   = (count_q == CNT_WIDTH'(DEPTH));
    assign accept_c = in_valid && !full_c;
    assign push_c   = accept_c && supported_c && !flush;
    assign pop_c    = (count_q != '0) && out_ready && !flush;

    // FIFO next-state; flush clears pointers, occupancy and the error pulse.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = accept_c && !supported_c && !flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                mem_d[wr_ptr_q] = enc_c;
                wr_ptr_d        = PTR_W'(wr_ptr_q + PTR_W'(1));
            end
            if (pop_c) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
            end
            case ({push_c, pop_c})
                2'b10:   count_d = CNT_WIDTH'(count_q + CNT_WIDTH'(1));
                2'b01:   count_d = CNT_WIDTH'(count_q - CNT_WIDTH'(1));
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = !full_c;
    assign out_valid = (count_q != '0);
    assign out_inst  = mem_q[rd_ptr_q];
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with an expected-word scoreboard queue.

`ifndef INST_NUM_WIDTH
`define INST_NUM_WIDTH 3
`endif
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef INV
`define INV    3'd0
`endif
`ifndef ADDI
`define ADDI   3'd1
`endif
`ifndef ADD
`define ADD    3'd2
`endif
`ifndef LW
`define LW     3'd3
`endif
`ifndef SW
`define SW     3'd4
`endif
`ifndef BEQ
`define BEQ    3'd5
`endif
`ifndef EBREAK
`define EBREAK 3'd6
`endif

module tb_inst_encoder;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned CNT_WIDTH = 3;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [`INST_NUM_WIDTH-1:0] in_num;
    logic [4:0]                 in_rd;
    logic [4:0]                 in_rs1;
    logic [4:0]                 in_rs2;
    logic [31:0]                in_imm;
    logic                       out_valid;
    logic                       out_ready;
    logic [`ISA_WIDTH-1:0]      out_inst;
    logic                       err;
    logic [CNT_WIDTH-1:0]       count;

    logic [31:0] exp_q [$];
    logic [31:0] cur_exp;
    logic        cur_supported;
    logic        err_exp;
    int          n_checks = 0;
    int          n_fail   = 0;

    inst_encoder #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare outputs against the model mid-cycle, then advance the model
    // with the inputs the DUT will sample at the coming edge.
    task automatic tick();
        int sz;
        @(negedge clk);
        sz = exp_q.size();
        chk("count", 32'(count), 32'(sz));
        chk("out_valid", 32'(out_valid), 32'(sz != 0));
        chk("in_ready", 32'(in_ready), 32'(sz < int'(DEPTH)));
        chk("err", 32'(err), 32'(err_exp));
        if (sz != 0 && out_valid) begin
            chk("out_inst", out_inst, exp_q[0]);
        end
        if (rst || flush) begin
            exp_q.delete();
            err_exp = 1'b0;
        end else begin
            if (out_ready && sz != 0) void'(exp_q.pop_front());
            err_exp = in_valid && (sz < int'(DEPTH)) && !cur_supported;
            if (in_valid && (sz < int'(DEPTH)) && cur_supported) exp_q.push_back(cur_exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] num, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm,
                         input logic [31:0] exp, input logic sup);
        in_valid      = 1'b1;
        in_num        = num;
        in_rd         = rd;
        in_rs1        = rs1;
        in_rs2        = rs2;
        in_imm        = imm;
        cur_exp       = exp;
        cur_supported = sup;
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        cur_supported = 1'b1;
    endtask

    task automatic req(input logic [2:0] num, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] exp);
        drive(num, rd, rs1, rs2, imm, exp, 1'b1);
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; err_exp = 1'b0;
        in_num = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        cur_exp = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_inst", out_inst, 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;

        // Single word latency, then back-to-back streams with the consumer ready.
        out_ready = 1'b1;
        req(`ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
        idle(); tick();
        req(`ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3);
        req(`SW, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423);
        req(`LW, 5'd5, 5'd2, 5'd0, -32'sd4, 32'hFFC1_2283);
        req(`BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463);
        req(`BEQ, 5'd0, 5'd1, 5'd2, -32'sd4, 32'hFE20_8EE3);
        req(`EBREAK, 5'd7, 5'd7, 5'd7, 32'hFFFF_FFFF, 32'h0010_0073);
        idle(); tick(); tick();

        // Fill while stalled; a fifth request waits for space.
        out_ready = 1'b0;
        req(`ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_F005, 32'h0050_0093);
        req(`ADDI, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113);
        req(`ADDI, 5'd2, 5'd0, 5'd0, 32'd3, 32'h0030_0113);
        req(`ADDI, 5'd2, 5'd0, 5'd0, 32'd4, 32'h0040_0113);
        req(`ADDI, 5'd1, 5'd1, 5'd0, 32'h7FF, 32'h7FF0_8093);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        idle();
        repeat (6) tick();

        // Unsupported numbers pulse err and enqueue nothing.
        drive(`INV, 5'd1, 5'd1, 5'd1, 32'd1, 32'h0, 1'b0);
        tick();
        idle(); tick();
        drive(3'd7, 5'd1, 5'd1, 5'd1, 32'd1, 32'h0, 1'b0);
        tick();
        req(`ADD, 5'd4, 5'd4, 5'd4, 32'd0, 32'h0042_0233);
        idle(); tick(); tick();

        // Flush with words queued and a push in the same cycle.
        out_ready = 1'b0;
        req(`EBREAK, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0010_0073);
        req(`EBREAK, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0010_0073);
        req(`EBREAK, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0010_0073);
        flush = 1'b1;
        req(`ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3);
        flush = 1'b0;
        idle(); tick(); tick();

        // Reset in the middle of a drain.
        req(`ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3);
        req(`LW, 5'd5, 5'd2, 5'd0, -32'sd4, 32'hFFC1_2283);
        req(`SW, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423);
        idle();
        out_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_inst", out_inst, 32'h0);
        chk("rst_mid_count", 32'(count), 32'h0);
        @(posedge clk);
        #1;
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
